// File: rtl/uart_rx_stream.sv
// ---------------------------------------------------------------------------
// uart_rx_stream
//
// UART receiver (8N1 / 8E1 / 8O1). The serial line is synchronised, each
// frame is sampled mid-bit, bytes are assembled LSB-first and pushed into a
// first-word-fall-through FIFO that is presented as a byte stream.
//
// Ports:
//   clk          in   system clock (single domain)
//   rst          in   synchronous, active-high reset
//   i_uart_rx    in   asynchronous serial line, idle high
//   o_tready     in   consumer ready
//   o_tvalid     out  FIFO non-empty, o_tdata valid
//   o_tdata      out  received byte at the FIFO head
//   o_frame_err  out  1-cycle pulse: stop bit sampled 0 (byte dropped)
//   o_parity_err out  1-cycle pulse: parity mismatch (byte dropped)
//   o_overflow   out  sticky: a good byte was dropped on a full FIFO
//
// Build option:
//   UART_RX_GLITCH_FILTER_EN  when defined, every bit decision is a 3-sample
//                             majority vote around mid-bit (one clk later).
// ---------------------------------------------------------------------------
module uart_rx_stream #(
    parameter int    CLK_FREQ  = 100000000,
    parameter int    BAUD_RATE = 115200,
    parameter string PARITY    = "NONE",
    parameter int    FIFO_EA   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_uart_rx,
    input  logic       o_tready,
    output logic       o_tvalid,
    output logic [7:0] o_tdata,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_overflow
);
    localparam int DIV     = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF    = DIV / 2;
    localparam int CW      = $clog2(DIV);
    localparam int PW      = FIFO_EA + 1;
    localparam int DEPTH   = 1 << FIFO_EA;
    localparam bit PAR_EN  = (PARITY != "NONE");
    localparam bit PAR_ODD = (PARITY == "ODD");

    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam logic [CW-1:0] SAMP_C  = CW'(HALF);
    localparam logic [CW-1:0] VOTE0_C = CW'(HALF - 2);
    localparam logic [CW-1:0] VOTE1_C = CW'(HALF - 1);
`else
    localparam logic [CW-1:0] SAMP_C  = CW'(HALF - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
    } state_t;

    // ---------------- input synchroniser ----------------
    logic sync1_q, rxs_q, rxs_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= i_uart_rx;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // ---------------- bit decision ----------------
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;
    logic          par_bad_q;
    logic          push_q, frame_err_q, parity_err_q;
    logic          smp_now, smp_bit;

    assign smp_now = (cnt_q == SAMP_C);

`ifdef UART_RX_GLITCH_FILTER_EN
    // Two early samples are kept; the third is the live bit at decision time.
    logic [1:0] vote_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vote_q <= 2'b11;
        end else begin
            if (cnt_q == VOTE0_C) vote_q[0] <= rxs_q;
            if (cnt_q == VOTE1_C) vote_q[1] <= rxs_q;
        end
    end

    assign smp_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs_q) | (vote_q[1] & rxs_q);
`else
    assign smp_bit = rxs_q;
`endif

    // ---------------- frame FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            par_bad_q    <= 1'b0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            cnt_q        <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (rxs_prev_q && !rxs_q) state_q <= S_START;
                end
                S_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (smp_now) begin
                        bit_idx_q <= '0;
                        par_bad_q <= 1'b0;
                        state_q   <= smp_bit ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (smp_now) begin
                        shreg_q   <= {smp_bit, shreg_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= PAR_EN ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    if (smp_now) begin
                        par_bad_q <= (((^shreg_q) ^ smp_bit) != PAR_ODD);
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Leave mid-stop on success so the next start edge is caught.
                    if (smp_now) begin
                        if (smp_bit) begin
                            state_q <= S_IDLE;
                            if (par_bad_q) parity_err_q <= 1'b1;
                            else           push_q       <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Wait out a held-low line without treating it as a start.
                    if (rxs_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- FWFT FIFO ----------------
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
    logic [7:0]    tdata_q;
    logic          overflow_q;
    logic          empty, full, do_pop, do_push, head_bypass;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[FIFO_EA] != rd_q[FIFO_EA]) &&
                     (wr_q[FIFO_EA-1:0] == rd_q[FIFO_EA-1:0]);
    assign do_pop  = !empty && o_tready;
    assign do_push = push_q && (!full || do_pop);
    assign wr_d    = wr_q + PW'(do_push);
    assign rd_d    = rd_q + PW'(do_pop);
    // The byte being written becomes the new head when the FIFO drains to it.
    assign head_bypass = do_push && (wr_q[FIFO_EA-1:0] == rd_d[FIFO_EA-1:0]);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[FIFO_EA-1:0]] <= shreg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            tdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (push_q && full && !do_pop) overflow_q <= 1'b1;
            // Head register: reloaded only while data remains, else holds.
            if (wr_d != rd_d) tdata_q <= head_bypass ? shreg_q : mem[rd_d[FIFO_EA-1:0]];
        end
    end

    assign o_tvalid     = !empty;
    assign o_tdata      = tdata_q;
    assign o_frame_err  = frame_err_q;
    assign o_parity_err = parity_err_q;
    assign o_overflow   = overflow_q;

endmodule
